// File: rtl/keypad_digit_entry.sv
`default_nettype none
// ============================================================================
// Module      : keypad_digit_entry
// Description : Turns debounced keypad codes into a 6-digit right-justified
//               entry buffer with backspace, hold-to-clear, enter/commit and
//               a leading-zero blank mask for the seven-segment digits.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_digit_entry #(
    parameter bit          HEX_ENTRY      = 1'b0,
    parameter logic [31:0] CLEAR_HOLD     = 32'd50000000,
    parameter bit          CLEAR_ON_ENTER = 1'b1
) (
    input  logic        CLOCK_50,
    input  logic        Reset,
    input  logic [3:0]  debouncedKey,
    input  logic        debouncedValid,
    output logic [23:0] Digits,
    output logic [5:0]  BlankMask,
    output logic [2:0]  Len,
    output logic [23:0] Value,
    output logic        ValueValid,
    output logic        Overflow
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_HOLD     = 2'd1,
        S_CLEARED  = 2'd2,
        S_WAIT_REL = 2'd3
    } state_t;

    localparam logic [3:0]  c_KEY_BKSP = 4'hE;
    localparam logic [3:0]  c_KEY_ENTR = 4'hF;
    localparam logic [2:0]  c_MAX_LEN  = 3'd6;
    // Last counter value of the hold window; a zero setting behaves like one.
    localparam logic [31:0] c_HOLD_LAST = (CLEAR_HOLD == 32'd0) ? 32'd0 : (CLEAR_HOLD - 32'd1);

    state_t      state_q, state_d;
    logic        last_valid_q;
    logic [23:0] digits_q, digits_d;
    logic [2:0]  len_q, len_d;
    logic [23:0] value_q, value_d;
    logic        vv_q, vv_d;
    logic        ov_q, ov_d;
    logic [31:0] cnt_q, cnt_d;

    logic        w_new_key;
    logic        w_is_digit;
    logic [2:0]  w_len_eff;

    // Rising edge of valid is a keystroke; only IDLE acts on it.
    assign w_new_key  = debouncedValid & ~last_valid_q;
    assign w_is_digit = (debouncedKey <= 4'h9) || (HEX_ENTRY && (debouncedKey <= 4'hD));

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            last_valid_q <= 1'b0;
            digits_q     <= 24'h0;
            len_q        <= 3'd0;
            value_q      <= 24'h0;
            vv_q         <= 1'b0;
            ov_q         <= 1'b0;
            cnt_q        <= 32'd0;
        end else begin
            state_q      <= state_d;
            last_valid_q <= debouncedValid;
            digits_q     <= digits_d;
            len_q        <= len_d;
            value_q      <= value_d;
            vv_q         <= vv_d;
            ov_q         <= ov_d;
            cnt_q        <= cnt_d;
        end
    end

    // Next-state and keystroke actions.
    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        len_d    = len_q;
        value_d  = value_q;
        vv_d     = 1'b0;
        ov_d     = 1'b0;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (w_new_key) begin
                    if (debouncedKey == c_KEY_BKSP) begin
                        if (len_q != 3'd0) begin
                            digits_d = {4'h0, digits_q[23:4]};
                            len_d    = len_q - 3'd1;
                        end
                        cnt_d   = 32'd0;
                        state_d = S_HOLD;
                    end else if (debouncedKey == c_KEY_ENTR) begin
                        value_d = digits_q;
                        vv_d    = 1'b1;
                        if (CLEAR_ON_ENTER) begin
                            digits_d = 24'h0;
                            len_d    = 3'd0;
                        end
                        state_d = S_WAIT_REL;
                    end else begin
                        if (w_is_digit) begin
                            if (len_q == c_MAX_LEN) begin
                                ov_d = 1'b1;
                            end else if (!((len_q == 3'd0) && (debouncedKey == 4'h0))) begin
                                digits_d = {digits_q[19:0], debouncedKey};
                                len_d    = len_q + 3'd1;
                            end
                        end
                        state_d = S_WAIT_REL;
                    end
                end
            end
            S_HOLD: begin
                if (!debouncedValid) begin
                    cnt_d   = 32'd0;
                    state_d = S_IDLE;
                end else if (debouncedKey != c_KEY_BKSP) begin
                    cnt_d   = 32'd0;
                    state_d = S_WAIT_REL;
                end else if (cnt_q >= c_HOLD_LAST) begin
                    digits_d = 24'h0;
                    len_d    = 3'd0;
                    state_d  = S_CLEARED;
                end else begin
                    // Below the last value, so the increment can never wrap.
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_CLEARED, S_WAIT_REL: begin
                if (!debouncedValid) begin
                    cnt_d   = 32'd0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // An empty buffer still shows one '0', so at least one digit is lit.
    assign w_len_eff = (len_q == 3'd0) ? 3'd1 : len_q;

    for (genvar gi = 0; gi < 6; gi++) begin : g_blank
        localparam logic [2:0] c_IDX = 3'(gi);
        assign BlankMask[gi] = (c_IDX >= w_len_eff);
    end

    assign Digits     = digits_q;
    assign Len        = len_q;
    assign Value      = value_q;
    assign ValueValid = vv_q;
    assign Overflow   = ov_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_digit_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_digit_entry
// Description : Directed self-checking bench for keypad_digit_entry, with a
//               second instance using hex entry and retain-on-enter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_digit_entry;

    logic        clk;
    logic        rst;
    logic [3:0]  key;
    logic        valid;

    logic [23:0] dig1, val1, dig2, val2;
    logic [5:0]  bm1, bm2;
    logic [2:0]  len1, len2;
    logic        vv1, ov1, vv2, ov2;

    int checks   = 0;
    int failures = 0;
    int ov_cnt   = 0;
    int vv_cnt   = 0;

    keypad_digit_entry #(
        .HEX_ENTRY(1'b0), .CLEAR_HOLD(32'd100), .CLEAR_ON_ENTER(1'b1)
    ) dut (
        .CLOCK_50(clk), .Reset(rst), .debouncedKey(key), .debouncedValid(valid),
        .Digits(dig1), .BlankMask(bm1), .Len(len1), .Value(val1),
        .ValueValid(vv1), .Overflow(ov1)
    );

    keypad_digit_entry #(
        .HEX_ENTRY(1'b1), .CLEAR_HOLD(32'd100), .CLEAR_ON_ENTER(1'b0)
    ) dut2 (
        .CLOCK_50(clk), .Reset(rst), .debouncedKey(key), .debouncedValid(valid),
        .Digits(dig2), .BlankMask(bm2), .Len(len2), .Value(val2),
        .ValueValid(vv2), .Overflow(ov2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters for the main instance.
    always @(negedge clk) begin
        if (ov1) ov_cnt++;
        if (vv1) vv_cnt++;
    end

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key   = k;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; key = 4'h0; valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (dig1 !== 24'h0) begin failures++; $display("FAIL reset_digits got=%h exp=%h", dig1, 24'h0); end
        checks++; if (len1 !== 3'd0) begin failures++; $display("FAIL reset_len got=%0d exp=0", len1); end
        checks++; if (val1 !== 24'h0) begin failures++; $display("FAIL reset_value got=%h exp=0", val1); end
        checks++; if (vv1 !== 1'b0) begin failures++; $display("FAIL reset_vv got=%b exp=0", vv1); end
        checks++; if (ov1 !== 1'b0) begin failures++; $display("FAIL reset_ov got=%b exp=0", ov1); end
        checks++; if (bm1 !== 6'b111110) begin failures++; $display("FAIL reset_mask got=%b exp=111110", bm1); end
        rst = 1'b0;
    endtask

    task automatic test_digits();
        do_reset();
        press(4'h1); press(4'h2); press(4'h3);
        checks++; if (dig1 !== 24'h000123) begin failures++; $display("FAIL digits_123 got=%h exp=000123", dig1); end
        checks++; if (len1 !== 3'd3) begin failures++; $display("FAIL digits_len got=%0d exp=3", len1); end
        checks++; if (bm1 !== 6'b111000) begin failures++; $display("FAIL digits_mask got=%b exp=111000", bm1); end
    endtask

    task automatic test_overflow();
        int ov0;
        do_reset();
        press(4'h0); press(4'h0); press(4'h7);
        checks++; if (dig1 !== 24'h000007) begin failures++; $display("FAIL lz_digits got=%h exp=000007", dig1); end
        checks++; if (len1 !== 3'd1) begin failures++; $display("FAIL lz_len got=%0d exp=1", len1); end
        checks++; if (bm1 !== 6'b111110) begin failures++; $display("FAIL lz_mask got=%b exp=111110", bm1); end
        ov0 = ov_cnt;
        for (int i = 0; i < 8; i++) press(4'h9);
        checks++; if (dig1 !== 24'h799999) begin failures++; $display("FAIL ovf_digits got=%h exp=799999", dig1); end
        checks++; if (len1 !== 3'd6) begin failures++; $display("FAIL ovf_len got=%0d exp=6", len1); end
        checks++; if (ov_cnt - ov0 !== 3) begin failures++; $display("FAIL ovf_pulses got=%0d exp=3", ov_cnt - ov0); end
        checks++; if (bm1 !== 6'b000000) begin failures++; $display("FAIL ovf_mask got=%b exp=000000", bm1); end
    endtask

    task automatic test_backspace();
        do_reset();
        press(4'h4); press(4'h5); press(4'h6);
        press(4'hE); press(4'hE);
        checks++; if (dig1 !== 24'h000004) begin failures++; $display("FAIL bs_digits got=%h exp=000004", dig1); end
        checks++; if (len1 !== 3'd1) begin failures++; $display("FAIL bs_len got=%0d exp=1", len1); end
        press(4'hE); press(4'hE);
        checks++; if (dig1 !== 24'h0) begin failures++; $display("FAIL bs_empty_digits got=%h exp=0", dig1); end
        checks++; if (len1 !== 3'd0) begin failures++; $display("FAIL bs_empty_len got=%0d exp=0", len1); end
        checks++; if (vv1 !== 1'b0 || ov1 !== 1'b0) begin failures++; $display("FAIL bs_pulses got=%b%b exp=00", vv1, ov1); end
    endtask

    task automatic test_enter();
        int vv0;
        do_reset();
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
        checks++; if (dig1 !== 24'h012345) begin failures++; $display("FAIL ent_pre got=%h exp=012345", dig1); end
        checks++; if (bm1 !== 6'b100000) begin failures++; $display("FAIL ent_mask got=%b exp=100000", bm1); end
        @(negedge clk);
        key = 4'hF; valid = 1'b1;
        @(negedge clk);
        checks++; if (vv1 !== 1'b1) begin failures++; $display("FAIL ent_vv got=%b exp=1", vv1); end
        checks++; if (val1 !== 24'h012345) begin failures++; $display("FAIL ent_value got=%h exp=012345", val1); end
        checks++; if (dig1 !== 24'h0 || len1 !== 3'd0) begin failures++; $display("FAIL ent_clear got=%h/%0d exp=0/0", dig1, len1); end
        checks++; if (dig2 !== 24'h012345 || len2 !== 3'd5) begin failures++; $display("FAIL ent_retain got=%h/%0d exp=012345/5", dig2, len2); end
        checks++; if (val2 !== 24'h012345 || vv2 !== 1'b1) begin failures++; $display("FAIL ent_value2 got=%h/%b exp=012345/1", val2, vv2); end
        valid = 1'b0;
        @(negedge clk);
        checks++; if (vv1 !== 1'b0) begin failures++; $display("FAIL ent_vv_one got=%b exp=0", vv1); end
        @(negedge clk);
        vv0 = vv_cnt;
        press(4'hF);
        checks++; if (vv_cnt - vv0 !== 1) begin failures++; $display("FAIL ent_empty_pulse got=%0d exp=1", vv_cnt - vv0); end
        checks++; if (val1 !== 24'h0) begin failures++; $display("FAIL ent_empty_value got=%h exp=0", val1); end
    endtask

    task automatic test_hold_clear();
        do_reset();
        press(4'h7); press(4'h8); press(4'h9);
        @(negedge clk);
        key = 4'hE; valid = 1'b1;
        for (int n = 1; n <= 150; n++) begin
            @(negedge clk);
            if (n == 1) begin
                checks++; if (dig1 !== 24'h000078) begin failures++; $display("FAIL hold_first got=%h exp=000078", dig1); end
            end
            if (n == 100) begin
                checks++; if (dig1 !== 24'h000078) begin failures++; $display("FAIL hold_early got=%h exp=000078", dig1); end
            end
            if (n == 101) begin
                checks++; if (dig1 !== 24'h0) begin failures++; $display("FAIL hold_clear got=%h exp=0", dig1); end
            end
        end
        checks++; if (dig1 !== 24'h0 || len1 !== 3'd0) begin failures++; $display("FAIL hold_end got=%h/%0d exp=0/0", dig1, len1); end
        valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        do_reset();
        press(4'h7); press(4'h8); press(4'h9);
        @(negedge clk);
        key = 4'hE; valid = 1'b1;
        repeat (50) @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (dig1 !== 24'h000078 || len1 !== 3'd2) begin failures++; $display("FAIL hold_short got=%h/%0d exp=000078/2", dig1, len1); end
        // Switching away from backspace mid-hold abandons the clear.
        press(4'h1);
        @(negedge clk);
        key = 4'hE; valid = 1'b1;
        repeat (10) @(negedge clk);
        key = 4'h5;
        repeat (140) @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (dig1 !== 24'h000078 || len1 !== 3'd2) begin failures++; $display("FAIL hold_switch got=%h/%0d exp=000078/2", dig1, len1); end
    endtask

    task automatic test_hex_and_change();
        int ov0;
        do_reset();
        ov0 = ov_cnt;
        press(4'hB);
        checks++; if (dig1 !== 24'h0 || len1 !== 3'd0) begin failures++; $display("FAIL hex_ignore got=%h/%0d exp=0/0", dig1, len1); end
        checks++; if (ov_cnt !== ov0) begin failures++; $display("FAIL hex_no_pulse got=%0d exp=%0d", ov_cnt, ov0); end
        checks++; if (dig2 !== 24'h00000B || len2 !== 3'd1) begin failures++; $display("FAIL hex_accept got=%h/%0d exp=00000b/1", dig2, len2); end
        do_reset();
        @(negedge clk);
        key = 4'h5; valid = 1'b1;
        @(negedge clk);
        key = 4'h6;
        repeat (5) @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (dig1 !== 24'h000005 || len1 !== 3'd1) begin failures++; $display("FAIL key_change got=%h/%0d exp=000005/1", dig1, len1); end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        press(4'h1); press(4'h2); press(4'hF);
        press(4'h1); press(4'h2);
        @(negedge clk);
        key = 4'hE; valid = 1'b1;
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (dig1 !== 24'h0 || len1 !== 3'd0 || val1 !== 24'h0) begin failures++; $display("FAIL rst_async got=%h/%0d/%h exp=0/0/0", dig1, len1, val1); end
        checks++; if (bm1 !== 6'b111110 || vv1 !== 1'b0 || ov1 !== 1'b0) begin failures++; $display("FAIL rst_async_out got=%b/%b/%b exp=111110/0/0", bm1, vv1, ov1); end
        key = 4'h4;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (dig1 !== 24'h000004 || len1 !== 3'd1) begin failures++; $display("FAIL rst_held_key got=%h/%0d exp=000004/1", dig1, len1); end
        repeat (5) @(negedge clk);
        checks++; if (len1 !== 3'd1) begin failures++; $display("FAIL rst_held_once got=%0d exp=1", len1); end
        valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_digits();
        test_overflow();
        test_backspace();
        test_enter();
        test_hold_clear();
        test_hex_and_change();
        test_reset_mid_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_digit_entry.md
Name: keypad_digit_entry

Overview:
Downstream consumer of the keypad debouncer. It turns debounced key codes into a 6-digit right-justified entry buffer that drives the six SevenSegment instances. It provides backspace, hold-to-clear and enter/commit, and generates the per-digit leading-zero blank mask. It replaces ad-hoc digit shifting in the top level with one registered, verifiable block.

Parameters:
HEX_ENTRY, 0, 1 = keys 0xA–0xD are entered as digits; 0 = keys 0xA–0xD are ignored.
CLEAR_HOLD, 50000000, cycles backspace (0xE) must be held continuously to clear the buffer (1 s at 50 MHz); 32-bit compare.
CLEAR_ON_ENTER, 1, 1 = buffer clears after enter; 0 = buffer is retained after enter.

Ports:
CLOCK_50  input  1  system clock; all state is on posedge.
Reset  input  1  asynchronous, active-high; clears all state immediately.
debouncedKey  input  4  key code from the debouncer: 0x0–0xD are digits, 0xE = '*' (backspace), 0xF = '#' (enter).
debouncedValid  input  1  high while a debounced key is held.
Digits  output  24  entry buffer; Digit0 = [3:0] (rightmost) … Digit5 = [23:20].
BlankMask  output  6  drives SevenSegment blankZero per digit; 1 = blank if zero.
Len  output  3  count of significant digits entered, 0..6.
Value  output  24  buffer contents captured at the last enter.
ValueValid  output  1  one-cycle pulse when Value updates.
Overflow  output  1  one-cycle pulse when a digit is rejected because the buffer is full.

Behaviour:
- Reset values: Digits=0, Len=0, Value=0, ValueValid=0, Overflow=0, BlankMask=6'b111110, LastValid=0, state=IDLE, hold counter=0.
- Keystroke event:
  - A new keystroke is registered when debouncedValid=1 and LastValid=0. The key is sampled that same cycle.
  - LastValid <= debouncedValid every cycle.
  - Resulting register updates are visible one clock after the sampling edge.
- Key changes while debouncedValid stays high are not new keystrokes. debouncedValid must drop first.
- Digit key (0x0–0x9; also 0xA–0xD when HEX_ENTRY=1):
  - Len==0 and key==0: no change. Leading zeros are not counted.
  - Len<6: Digits <= {Digits[19:0], key}; Len <= Len+1.
  - Len==6: Digits and Len unchanged; Overflow pulses for 1 cycle.
- 0xA–0xD with HEX_ENTRY=0: ignored, no pulse.
- Backspace (0xE):
  - Len>0: Digits <= {4'h0, Digits[23:4]}; Len <= Len-1.
  - Len==0: no change.
- Enter (0xF): Value <= Digits; ValueValid pulses for 1 cycle. If CLEAR_ON_ENTER=1, Digits <= 0 and Len <= 0 in the same cycle. Enter with Len==0 still commits Value=0 and pulses.
- BlankMask[i] = 1 for i >= max(Len,1), otherwise 0. BlankMask[0] is always 0, so an empty buffer shows a single "0". The mask is combinational from the Len register.
- State machine:
  - IDLE: on a new keystroke, perform the action above.
    - key==0xE → HOLD, hold counter=0.
    - any other key → WAIT_REL.
  - HOLD:
    - debouncedValid=0 → IDLE.
    - debouncedKey≠0xE while valid → WAIT_REL, counter cleared, no clear.
    - otherwise counter++; when counter reaches CLEAR_HOLD-1: Digits <= 0, Len <= 0 → CLEARED.
  - CLEARED, WAIT_REL: stay until debouncedValid=0 → IDLE.
  - Only IDLE accepts new keystrokes. The LastValid edge detector must agree with the state; IDLE is never left without a keystroke.
- The hold counter saturates. It never wraps, even if CLEAR_HOLD is near 2^32.
- ValueValid and Overflow are never high in the same cycle. Each is high for exactly 1 cycle per event.
- Reset asserted mid-hold or mid-keystroke:
  - All state returns to reset values asynchronously.
  - After deassertion, a key already held (debouncedValid=1) is a new keystroke only if LastValid=0. LastValid resets to 0, so a held key is accepted once.

Test Plan:
- Reset, then keys 1,2,3 (each press/release) → Digits=0x000123, Len=3, BlankMask=6'b111000.
- From reset, keys 0,0,7 → Digits=0x000007, Len=1, BlankMask=6'b111110. Then 8 keys of 9 → 5 accepted; Len=6, Digits=0x799999; Overflow pulses exactly 3 times.
- Digits=0x000456: backspace ×2 → Digits=0x000004, Len=1. A third and fourth backspace → Digits=0, Len=0, no other effect.
- Digits=0x012345, press '#' → Value=0x012345, ValueValid high 1 cycle, Digits=0, Len=0 (CLEAR_ON_ENTER=1). With CLEAR_ON_ENTER=0, Digits is retained.
- With CLEAR_HOLD=100 and Digits=0x000789:
  - hold 0xE for 150 cycles → one backspace at press, then cleared at cycle 100 (Digits=0, Len=0), nothing further until release.
  - hold 0xE for 50 cycles → only Digits=0x000078.
- HEX_ENTRY=0, key B → ignored. Key 5 held with debouncedKey switched to 6 without release → only 5 entered. Reset asserted mid-hold → all outputs at reset values within the same cycle.
